// File: rtl/jtvigil_sndcmd.sv
`timescale 1ns/1ps
// jtvigil_sndcmd
// Main-CPU-side sound command queue. Command bytes from the main CPU are
// buffered in a small circular FIFO and handed to the sound latch one at a
// time; the next byte is withheld until the sound CPU acknowledges the
// previous one or the acknowledge timeout expires.
module jtvigil_sndcmd #(
  parameter int unsigned AW   = 2,
  parameter logic [15:0] TOUT = 16'd4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_wr,
  input  logic [7:0]    main_din,
  input  logic          flush,
  input  logic          snd_ack,
  output logic [7:0]    latch_dout,
  output logic          latch_wr,
  output logic          pending,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0] TLAST    = TOUT - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t         state, state_nxt;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt;
  logic [15:0]    tcnt;
  logic           pop, push, drop, tout_hit;

  // Timeout fires on the last WAIT cycle; TOUT of zero never fires.
  always_comb tout_hit = (TOUT != 16'd0) && (tcnt == TLAST);

  // Next-state and pop decision for the delivery FSM; flush wins over all.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cnt != '0) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (snd_ack || tout_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      pop       = 1'b0;
    end
  end

  // A write into a full FIFO is still accepted when the head leaves on the
  // same edge, because the slot being written is the one being read out.
  always_comb begin
    push = main_wr && !flush && (!full || pop);
    drop = main_wr && !flush && full && !pop;
  end

  // Delivery FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= main_din;
  end

  // Output latch captures the head byte on the pop edge and holds it.
  always_ff @(posedge clk) begin
    if (rst)      latch_dout <= '0;
    else if (pop) latch_dout <= mem[rd_ptr];
  end

  // Acknowledge timeout counter, zero everywhere outside WAIT.
  always_ff @(posedge clk) begin
    if (rst)                  tcnt <= '0;
    else if (state == ST_WAIT) tcnt <= tcnt + 16'd1;
    else                      tcnt <= '0;
  end

  // Outputs come straight from registers only.
  always_comb begin
    latch_wr = (state == ST_SEND);
    pending  = (state != ST_IDLE);
    empty    = (cnt == '0);
    full     = (cnt == FULL_CNT);
    level    = cnt;
  end

endmodule

// File: tb/tb_jtvigil_sndcmd.sv
`timescale 1ns/1ps
// Directed self-checking bench for jtvigil_sndcmd (AW=2, TOUT=16).
module tb_jtvigil_sndcmd;

  logic       clk = 1'b0;
  logic       rst, main_wr, flush, snd_ack;
  logic [7:0] main_din;
  logic [7:0] latch_dout;
  logic       latch_wr, pending, empty, full, ovf;
  logic [2:0] level;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] got[$];
  int         got_cyc[$];

  jtvigil_sndcmd #(.AW(2), .TOUT(16'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .main_wr    (main_wr),
    .main_din   (main_din),
    .flush      (flush),
    .snd_ack    (snd_ack),
    .latch_dout (latch_dout),
    .latch_wr   (latch_wr),
    .pending    (pending),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every latch write (byte and cycle) away from the active edge.
  always @(negedge clk) begin
    if (latch_wr === 1'b1) begin
      got.push_back(latch_dout);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    main_wr  = 1'b1;
    main_din = b;
    tick();
    main_wr  = 1'b0;
  endtask

  task automatic ack();
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int g;
    g = 0;
    while (got.size() < n && g < 60) begin
      tick();
      g++;
    end
    chk(tag, 16'(got.size() >= n), 16'd1);
  endtask

  initial begin
    rst = 1'b1; main_wr = 1'b0; main_din = '0; flush = 1'b0; snd_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_dout",    16'(latch_dout), 16'h00);
    chk("rst_wr",      16'(latch_wr),   16'd0);
    chk("rst_pending", 16'(pending),    16'd0);
    chk("rst_empty",   16'(empty),      16'd1);
    chk("rst_full",    16'(full),       16'd0);
    chk("rst_level",   16'(level),      16'd0);
    chk("rst_ovf",     16'(ovf),        16'd0);

    // Single byte: level after write edge, latch_wr one edge later
    push(8'hA5);
    chk("s_level1",  16'(level),      16'd1);
    chk("s_empty0",  16'(empty),      16'd0);
    chk("s_wr0",     16'(latch_wr),   16'd0);
    tick();
    chk("s_wr1",     16'(latch_wr),   16'd1);
    chk("s_dout",    16'(latch_dout), 16'hA5);
    chk("s_pend1",   16'(pending),    16'd1);
    chk("s_emptyp",  16'(empty),      16'd1);
    tick();
    chk("s_wr_once", 16'(latch_wr),   16'd0);
    chk("s_pend_w",  16'(pending),    16'd1);
    ack();
    chk("s_pend0",   16'(pending),    16'd0);
    chk("s_empty1",  16'(empty),      16'd1);
    chk("s_hold",    16'(latch_dout), 16'hA5);

    // Acknowledge in IDLE and in SEND is ignored and not remembered
    ack();
    push(8'h3C);
    tick();
    chk("ig_send",   16'(latch_wr),   16'd1);
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
    chk("ig_pend_a", 16'(pending),    16'd1);
    tick();
    chk("ig_pend_b", 16'(pending),    16'd1);
    ack();
    chk("ig_pend0",  16'(pending),    16'd0);

    // Burst of 5: 01 leaves immediately, 02..05 fill the FIFO
    got.delete(); got_cyc.delete();
    main_wr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      main_din = 8'(i);
      tick();
    end
    main_wr = 1'b0;
    chk("b_full",  16'(full),  16'd1);
    chk("b_level", 16'(level), 16'd4);
    chk("b_ovf",   16'(ovf),   16'd0);
    for (int k = 0; k < 5; k++) begin
      wait_got(k + 1, "b_deliver");
      repeat (7) tick();
      ack();
    end
    chk("b_count", 16'(got.size()), 16'd5);
    for (int k = 0; k < 5; k++)
      chk("b_order", 16'((got.size() > k) ? got[k] : 8'hxx), 16'(k + 1));
    chk("b_empty", 16'(empty), 16'd1);

    // Overflow while WAIT blocks, then flush together with a write
    got.delete(); got_cyc.delete();
    push(8'h10);
    tick();
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    push(8'h77);
    chk("o_ovf",   16'(ovf),     16'd1);
    chk("o_level", 16'(level),   16'd4);
    chk("o_full",  16'(full),    16'd1);
    chk("o_pend",  16'(pending), 16'd1);
    flush = 1'b1; main_wr = 1'b1; main_din = 8'h88;
    tick();
    flush = 1'b0; main_wr = 1'b0;
    chk("f_level", 16'(level),      16'd0);
    chk("f_ovf",   16'(ovf),        16'd0);
    chk("f_empty", 16'(empty),      16'd1);
    chk("f_pend",  16'(pending),    16'd0);
    chk("f_dout",  16'(latch_dout), 16'h10);
    repeat (4) tick();
    chk("o_no77",  16'(got.size()), 16'd1);

    // Flush on the pop edge aborts the pending latch write
    push(8'h20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("a_wr",    16'(latch_wr),   16'd0);
    chk("a_level", 16'(level),      16'd0);
    chk("a_dout",  16'(latch_dout), 16'h10);
    repeat (3) tick();
    chk("a_none",  16'(got.size()), 16'd1);

    // Timeout: no acknowledge, pulses TOUT+2 = 18 cycles apart
    got.delete(); got_cyc.delete();
    push(8'h31);
    push(8'h32);
    wait_got(2, "t_second");
    chk("t_b0",  16'((got.size() > 0) ? got[0] : 8'hxx), 16'h31);
    chk("t_b1",  16'((got.size() > 1) ? got[1] : 8'hxx), 16'h32);
    chk("t_gap", 16'((got_cyc.size() > 1) ? (got_cyc[1] - got_cyc[0]) : 0), 16'd18);
    ack();

    // Wrap-around: 10 push/ack rounds across pointer wrap
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      push(8'hC0 + 8'(i));
      wait_got(i + 1, "w_deliver");
      ack();
    end
    for (int i = 0; i < 10; i++)
      chk("w_byte", 16'((got.size() > i) ? got[i] : 8'hxx), 16'(8'hC0 + 8'(i)));

    // Write while full on the IDLE pop edge is accepted
    got.delete(); got_cyc.delete();
    push(8'h50);
    tick();
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    ack();
    chk("p_level4", 16'(level),   16'd4);
    chk("p_idle",   16'(pending), 16'd0);
    push(8'h55);
    chk("p_level",  16'(level),      16'd4);
    chk("p_wr",     16'(latch_wr),   16'd1);
    chk("p_dout",   16'(latch_dout), 16'h51);
    chk("p_ovf",    16'(ovf),        16'd0);
    for (int k = 1; k < 6; k++) begin
      wait_got(k + 1, "p_deliver");
      ack();
    end
    for (int k = 0; k < 6; k++)
      chk("p_order", 16'((got.size() > k) ? got[k] : 8'hxx), 16'(8'h50 + 8'(k)));

    // Synchronous reset during WAIT with a byte queued
    got.delete(); got_cyc.delete();
    push(8'h66);
    tick();
    push(8'h67);
    chk("r_pre",     16'(pending), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_dout",    16'(latch_dout), 16'h00);
    chk("r_wr",      16'(latch_wr),   16'd0);
    chk("r_pending", 16'(pending),    16'd0);
    chk("r_empty",   16'(empty),      16'd1);
    chk("r_full",    16'(full),       16'd0);
    chk("r_level",   16'(level),      16'd0);
    chk("r_ovf",     16'(ovf),        16'd0);
    repeat (4) tick();
    chk("r_lost",    16'(got.size()), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
